smem_rectfill: RTL and testbench

Rectangle fill engine upstream of the screen memory. It drives the memory's CPU-side write port (write enable, address, write data). Given a rectangle origin, size, character value and mode, it writes that value into every covered cell at one write per clock: the whole area in solid mode, or the border only in outline mode. The rectangle is clipped to the 80×60 screen, and completion is reported with a `busy` level and a `done` pulse.

---
 rtl/smem_pkg.sv | 26 ++
 rtl/smem_rectfill_if.sv | 28 ++
 rtl/smem_rect_clip.sv | 27 ++
 rtl/smem_rectfill.sv | 144 ++++++++++++++
 tb/tb_smem_rectfill.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/smem_pkg.sv
// Shared constants, widths and state type for the screen-memory rectangle fill engine.
package smem_pkg;

    localparam int NCOLS = 80;
    localparam int NROWS = 60;
    localparam int NLOC  = NCOLS * NROWS;
    localparam int DBITS = 4;

    localparam int XW = $clog2(NCOLS);
    localparam int YW = $clog2(NROWS);
    localparam int WW = $clog2(NCOLS + 1);
    localparam int HW = $clog2(NROWS + 1);
    localparam int AW = $clog2(NLOC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } rectfill_state_t;

    // y*80 as two shifted adds; only valid while NCOLS stays at 80.
    function automatic logic [AW-1:0] row_base_of(input logic [YW-1:0] y);
        return (AW'(y) << 6) + (AW'(y) << 4);
    endfunction

endpackage

// File: rtl/smem_rectfill_if.sv
// Command and memory-write-port bundle between a command source and the rectangle fill engine.
interface smem_rectfill_if;
    import smem_pkg::*;

    logic             start;
    logic             mode;
    logic [XW-1:0]    x0;
    logic [YW-1:0]    y0;
    logic [WW-1:0]    w;
    logic [HW-1:0]    h;
    logic [DBITS-1:0] value;
    logic             busy;
    logic             done;
    logic             wr;
    logic [AW-1:0]    smem_addr;
    logic [DBITS-1:0] smem_writedata;

    modport master (
        output start, mode, x0, y0, w, h, value,
        input  busy, done, wr, smem_addr, smem_writedata
    );

    modport slave (
        input  start, mode, x0, y0, w, h, value,
        output busy, done, wr, smem_addr, smem_writedata
    );

endinterface

// File: rtl/smem_rect_clip.sv
// Clips a rectangle request against the screen edges; an origin off the screen yields zero size.
module smem_rect_clip
    import smem_pkg::*;
(
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [WW-1:0] w,
    input  logic [HW-1:0] h,
    output logic [WW-1:0] cw,
    output logic [HW-1:0] ch,
    output logic          zero
);

    logic [WW-1:0] room_x;
    logic [HW-1:0] room_y;

    always_comb begin
        room_x = '0;
        room_y = '0;
        if (x0 < XW'(NCOLS)) room_x = WW'(NCOLS) - WW'(x0);
        if (y0 < YW'(NROWS)) room_y = HW'(NROWS) - HW'(y0);
        cw   = (w < room_x) ? w : room_x;
        ch   = (h < room_y) ? h : room_y;
        zero = (cw == '0) || (ch == '0);
    end

endmodule

// File: rtl/smem_rectfill.sv
// Rectangle fill engine: one registered write per clock over a clipped solid or outlined rectangle.
module smem_rectfill
    import smem_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    smem_rectfill_if.slave bus
);

    rectfill_state_t  state_q, state_d;
    logic             outline_q, outline_d;
    logic [XW-1:0]    x_first_q, x_first_d;
    logic [XW-1:0]    x_last_q, x_last_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    row_q, row_d;
    logic [YW-1:0]    row_last_q, row_last_d;
    logic [AW-1:0]    row_base_q, row_base_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DBITS-1:0] data_q, data_d;
    logic             wr_q, wr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WW-1:0]    clip_cw;
    logic [HW-1:0]    clip_ch;
    logic             clip_zero;
    logic             row_done;
    logic             last_cell;
    logic             interior;

    smem_rect_clip u_clip (
        .x0   (bus.x0),
        .y0   (bus.y0),
        .w    (bus.w),
        .h    (bus.h),
        .cw   (clip_cw),
        .ch   (clip_ch),
        .zero (clip_zero)
    );

    always_comb begin
        state_d    = state_q;
        outline_d  = outline_q;
        x_first_d  = x_first_q;
        x_last_d   = x_last_q;
        x_d        = x_q;
        row_d      = row_q;
        row_last_d = row_last_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        // The registers describe the cell being presented now; _d is the next cell.
        row_done  = (x_q == x_last_q);
        last_cell = row_done && (row_q == row_last_q);
        interior  = outline_q && (row_q != '0) && (row_q != row_last_q);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d = bus.value;
                    if (clip_zero) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = WRITE;
                        wr_d       = 1'b1;
                        busy_d     = 1'b1;
                        outline_d  = bus.mode;
                        x_first_d  = bus.x0;
                        x_last_d   = bus.x0 + XW'(clip_cw) - XW'(1);
                        x_d        = bus.x0;
                        row_d      = '0;
                        row_last_d = YW'(clip_ch) - YW'(1);
                        row_base_d = row_base_of(bus.y0);
                        addr_d     = row_base_of(bus.y0) + AW'(bus.x0);
                    end
                end
            end
            WRITE: begin
                if (last_cell) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    wr_d   = 1'b1;
                    busy_d = 1'b1;
                    if (row_done) begin
                        x_d        = x_first_q;
                        row_d      = row_q + YW'(1);
                        row_base_d = row_base_q + AW'(NCOLS);
                        addr_d     = row_base_q + AW'(NCOLS) + AW'(x_first_q);
                    end else if (interior) begin
                        // Outline interior rows skip straight to the right edge.
                        x_d    = x_last_q;
                        addr_d = row_base_q + AW'(x_last_q);
                    end else begin
                        x_d    = x_q + XW'(1);
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clock) begin
        outline_q  <= outline_d;
        x_first_q  <= x_first_d;
        x_last_q   <= x_last_d;
        x_q        <= x_d;
        row_q      <= row_d;
        row_last_q <= row_last_d;
        row_base_q <= row_base_d;
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.wr             = wr_q;
    assign bus.smem_addr      = addr_q;
    assign bus.smem_writedata = data_q;

endmodule

// File: tb/tb_smem_rectfill.sv
// Randomized and directed bench for smem_rectfill against a cell-enumerating reference model.
module tb_smem_rectfill;
    import smem_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    smem_rectfill_if bus ();

    smem_rectfill dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
        end
    endtask

    // Visit every on-screen cell of the rectangle in raster order, keeping border cells in outline mode.
    function automatic void build_model(input logic m, input int x0, input int y0, input int w, input int h);
        int cw, ch;
        exp_q.delete();
        cw = (x0 >= NCOLS) ? 0 : ((w < NCOLS - x0) ? w : NCOLS - x0);
        ch = (y0 >= NROWS) ? 0 : ((h < NROWS - y0) ? h : NROWS - y0);
        for (int r = 0; r < ch; r++)
            for (int c = 0; c < cw; c++)
                if (!m || r == 0 || r == ch - 1 || c == 0 || c == cw - 1)
                    exp_q.push_back((y0 + r) * NCOLS + x0 + c);
    endfunction

    // inject: 0 none, 1 foreign start during cycle 3, 2 reset during cycle 3
    task automatic run_cmd(input logic m, input int x0, input int y0, input int w, input int h,
                           input int val, input int inject);
        int n;
        @(posedge clock);
        #1;
        bus.start = 1'b1;
        bus.mode  = m;
        bus.x0    = XW'(x0);
        bus.y0    = YW'(y0);
        bus.w     = WW'(w);
        bus.h     = HW'(h);
        bus.value = DBITS'(val);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("wr", 32'(bus.wr), 1);
            chk("addr", 32'(bus.smem_addr), exp_q[i]);
            chk("data", 32'(bus.smem_writedata), val);
            chk("busy", 32'(bus.busy), 1);
            chk("done_early", 32'(bus.done), 0);
            if (inject == 1 && i == 2) begin
                bus.start = 1'b1;
                bus.mode  = ~m;
                bus.x0    = '0;
                bus.y0    = '0;
                bus.w     = WW'(5);
                bus.h     = HW'(5);
                bus.value = ~DBITS'(val);
            end
            if (inject == 1 && i == 3) bus.start = 1'b0;
            if (inject == 2 && i == 2) begin
                reset = 1'b1;
                @(negedge clock);
                chk("rst_wr", 32'(bus.wr), 0);
                chk("rst_done", 32'(bus.done), 0);
                chk("rst_busy", 32'(bus.busy), 0);
                chk("rst_addr", 32'(bus.smem_addr), 0);
                chk("rst_data", 32'(bus.smem_writedata), 0);
                reset = 1'b0;
                @(negedge clock);
                chk("post_rst_wr", 32'(bus.wr), 0);
                chk("post_rst_done", 32'(bus.done), 0);
                return;
            end
        end
        @(negedge clock);
        chk("done", 32'(bus.done), 1);
        chk("fin_wr", 32'(bus.wr), 0);
        chk("fin_busy", 32'(bus.busy), 0);
        @(negedge clock);
        chk("done_pulse", 32'(bus.done), 0);
        chk("idle_wr", 32'(bus.wr), 0);
        chk("idle_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.x0    = '0;
        bus.y0    = '0;
        bus.w     = '0;
        bus.h     = '0;
        bus.value = '0;
        reset     = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_wr", 32'(bus.wr), 0);
        chk("reset_addr", 32'(bus.smem_addr), 0);
        chk("reset_data", 32'(bus.smem_writedata), 0);
        reset = 1'b0;

        exp_q = '{410, 411, 412, 490, 491, 492};
        run_cmd(1'b0, 10, 5, 3, 2, 7, 0);

        exp_q = '{0, 1, 2, 3, 80, 83, 160, 161, 162, 163};
        run_cmd(1'b1, 0, 0, 4, 3, 15, 0);

        exp_q = '{4798, 4799};
        run_cmd(1'b0, 78, 59, 5, 3, 9, 0);

        exp_q.delete();
        run_cmd(1'b0, 3, 3, 0, 4, 5, 0);
        exp_q.delete();
        run_cmd(1'b1, 80, 0, 5, 5, 5, 0);

        exp_q = '{410, 411, 412, 490, 491, 492};
        run_cmd(1'b0, 10, 5, 3, 2, 7, 1);

        exp_q = '{410, 411, 412, 490, 491, 492};
        run_cmd(1'b0, 10, 5, 3, 2, 7, 2);

        build_model(1'b1, 20, 10, 5, 4);
        run_cmd(1'b1, 20, 10, 5, 4, 3, 0);

        for (int k = 0; k < 40; k++) begin
            logic m;
            int x0, y0, w, h, v;
            m  = 1'($urandom_range(0, 1));
            x0 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(70, 127)) : int'($urandom_range(0, 79));
            y0 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(50, 63)) : int'($urandom_range(0, 59));
            w  = int'($urandom_range(0, 20));
            h  = int'($urandom_range(0, 12));
            v  = int'($urandom_range(0, 15));
            build_model(m, x0, y0, w, h);
            run_cmd(m, x0, y0, w, h, v, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
